// File: rtl/light_input_ctrl_if.sv
// Handshake bundle between the raw button/switch inputs and the light pattern block.
// master drives the raw inputs; slave is the input controller.
interface light_input_ctrl_if;
   logic       button_raw;
   logic [2:0] switch_raw;
   logic       start_pulse;
   logic       stop_pulse;
   logic       run;
   logic [2:0] pattern;
   logic       pattern_chg;

   modport master (
      output button_raw, switch_raw,
      input  start_pulse, stop_pulse, run, pattern, pattern_chg
   );

   modport slave (
      input  button_raw, switch_raw,
      output start_pulse, stop_pulse, run, pattern, pattern_chg
   );
endinterface

// File: rtl/light_input_ctrl.sv
// Push-button start/stop controller with debounced pattern switches.
// A short press starts the pattern; a long press while running stops it.
module light_input_ctrl #(
   parameter int unsigned DEBOUNCE_CYC   = 1000000,
   parameter int unsigned LONG_PRESS_CYC = 200000000
) (
   input  logic              clk,
   input  logic              rst_n,
   light_input_ctrl_if.slave bus
);
   localparam int unsigned NumIn = 4;
   localparam int unsigned DbW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int unsigned HoldW = (LONG_PRESS_CYC > 1) ? $clog2(LONG_PRESS_CYC) : 1;
   localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE_CYC - 1);
   localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_PRESS_CYC - 1);

   typedef enum logic [1:0] {StStopped, StStartHeld, StRunning, StStopHeld} state_e;

   // Bit 0 is the button, bits 3:1 are the pattern switches.
   logic [NumIn-1:0] raw_in;
   logic [NumIn-1:0] sync1_q, sync2_q;
   logic [NumIn-1:0] deb_d, deb_q;
   logic [DbW-1:0]   db_cnt_d [NumIn];
   logic [DbW-1:0]   db_cnt_q [NumIn];
   logic             btn_prev_q;

   state_e           state_d, state_q;
   logic [HoldW-1:0] hold_cnt_d, hold_cnt_q;
   logic             start_pulse_d, start_pulse_q;
   logic             stop_pulse_d, stop_pulse_q;
   logic [2:0]       pattern_d, pattern_q;
   logic             pattern_chg_d, pattern_chg_q;

   logic       btn_deb, btn_rise, hold_done;
   logic [2:0] sw_deb;

   assign raw_in = {bus.switch_raw, bus.button_raw};

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < NumIn; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DbMax) begin
               deb_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         btn_prev_q <= 1'b0;
         for (int i = 0; i < NumIn; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q    <= raw_in;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         btn_prev_q <= deb_q[0];
         for (int i = 0; i < NumIn; i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   assign btn_deb   = deb_q[0];
   assign sw_deb    = deb_q[3:1];
   assign btn_rise  = btn_deb & ~btn_prev_q;
   assign hold_done = btn_deb && (hold_cnt_q == HoldMax);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StStopped;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StStopped:   if (btn_rise) state_d = StStartHeld;
         StStartHeld: if (!btn_deb) state_d = StRunning;
         StRunning:   if (hold_done) state_d = StStopHeld;
         StStopHeld:  if (!btn_deb) state_d = StStopped;
         default:     state_d = StStopped;
      endcase
   end

   always_comb begin
      start_pulse_d = (state_q == StStopped) && btn_rise;
      stop_pulse_d  = (state_q == StRunning) && hold_done;
      hold_cnt_d    = '0;
      if ((state_q == StRunning) && btn_deb && !hold_done) begin
         hold_cnt_d = hold_cnt_q + HoldW'(1);
      end
      // Pattern tracks the switches only while stopped, including the edges
      // leaving and re-entering STOPPED, so a run always sees a frozen value.
      pattern_d     = pattern_q;
      pattern_chg_d = 1'b0;
      if (((state_q == StStopped) || (state_d == StStopped)) && (sw_deb != pattern_q)) begin
         pattern_d     = sw_deb;
         pattern_chg_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_cnt_q    <= '0;
         start_pulse_q <= 1'b0;
         stop_pulse_q  <= 1'b0;
         pattern_q     <= 3'b000;
         pattern_chg_q <= 1'b0;
      end else begin
         hold_cnt_q    <= hold_cnt_d;
         start_pulse_q <= start_pulse_d;
         stop_pulse_q  <= stop_pulse_d;
         pattern_q     <= pattern_d;
         pattern_chg_q <= pattern_chg_d;
      end
   end

   assign bus.start_pulse = start_pulse_q;
   assign bus.stop_pulse  = stop_pulse_q;
   assign bus.run         = (state_q == StStartHeld) || (state_q == StRunning);
   assign bus.pattern     = pattern_q;
   assign bus.pattern_chg = pattern_chg_q;
endmodule

// File: tb/tb_light_input_ctrl.sv
// Bench for light_input_ctrl: scenario table, random stimulus against a
// behavioural model, and exact start/stop latency sequences.
module tb_light_input_ctrl;
   localparam int unsigned Deb  = 4;
   localparam int unsigned Long = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   light_input_ctrl_if bus ();

   light_input_ctrl #(
      .DEBOUNCE_CYC  (Deb),
      .LONG_PRESS_CYC(Long)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Behavioural model
   typedef enum int {MStopped, MStartHeld, MRunning, MStopHeld} mmode_e;

   bit [3:0]   hist [0:Deb];   // raw samples, [0] = taken at the previous edge
   bit [3:0]   m_deb;
   bit         m_btn_prev;
   mmode_e     m_mode;
   int         m_press;
   bit [2:0]   m_pat;
   bit         m_start, m_stop, m_chg;

   always @(posedge clk) begin : model
      bit [3:0] deb_n;
      mmode_e   mode_n;
      int       press_n;
      bit [2:0] pat_n;
      bit       st, sp, ch, rise, all_diff;
      if (!rst_n) begin
         for (int k = 0; k <= Deb; k++) hist[k] <= '0;
         m_deb <= '0; m_btn_prev <= 1'b0; m_mode <= MStopped; m_press <= 0;
         m_pat <= '0; m_start <= 1'b0; m_stop <= 1'b0; m_chg <= 1'b0;
      end else begin
         mode_n = m_mode; press_n = m_press; pat_n = m_pat;
         st = 1'b0; sp = 1'b0; ch = 1'b0;
         rise = m_deb[0] && !m_btn_prev;
         case (m_mode)
            MStopped:   if (rise) begin mode_n = MStartHeld; st = 1'b1; end
            MStartHeld: if (!m_deb[0]) mode_n = MRunning;
            MRunning: begin
               if (m_deb[0]) begin
                  press_n = m_press + 1;
                  if (press_n == Long) begin sp = 1'b1; press_n = 0; mode_n = MStopHeld; end
               end else begin
                  press_n = 0;
               end
            end
            default:    if (!m_deb[0]) mode_n = MStopped;
         endcase
         if ((m_mode == MStopped || mode_n == MStopped) && m_deb[3:1] != m_pat) begin
            pat_n = m_deb[3:1];
            ch    = 1'b1;
         end
         // Synchronised sample at this edge is the raw value from two edges back;
         // a flip needs Deb consecutive such samples disagreeing with the level.
         deb_n = m_deb;
         for (int b = 0; b < 4; b++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= Deb; k++) if (hist[k][b] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) deb_n[b] = ~m_deb[b];
         end
         for (int k = Deb; k > 0; k--) hist[k] <= hist[k-1];
         hist[0] <= {bus.switch_raw, bus.button_raw};
         m_deb <= deb_n; m_btn_prev <= m_deb[0]; m_mode <= mode_n; m_press <= press_n;
         m_pat <= pat_n; m_start <= st; m_stop <= sp; m_chg <= ch;
      end
   end

   int checks   = 0;
   int failures = 0;
   int n_start  = 0;
   int n_stop   = 0;
   int n_chg    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (bus.start_pulse === 1'b1) n_start++;
      if (bus.stop_pulse === 1'b1)  n_stop++;
      if (bus.pattern_chg === 1'b1) n_chg++;
      check("cyc_start_pulse", 32'(bus.start_pulse), 32'(m_start));
      check("cyc_stop_pulse",  32'(bus.stop_pulse),  32'(m_stop));
      check("cyc_run",         32'(bus.run), 32'(m_mode == MStartHeld || m_mode == MRunning));
      check("cyc_pattern",     32'(bus.pattern),     32'(m_pat));
      check("cyc_pattern_chg", 32'(bus.pattern_chg), 32'(m_chg));
   endtask

   typedef struct {
      bit       rst;
      bit       btn;
      int       tog;
      bit [2:0] sw;
      int       n;
      bit       e_run;
      bit [2:0] e_pat;
      int       e_start;
      int       e_stop;
      int       e_chg;
   } vec_t;

   vec_t vecs [22];

   initial begin
      int s0, s1, s2, lat, found;
      bit run_at;
      bus.button_raw = 1'b0;
      bus.switch_raw = 3'b000;

      //         rst btn tog sw      n   run pat     st sp ch
      vecs[0]  = '{0, 0, 0, 3'b000, 3,  0, 3'b000, 0, 0, 0};
      vecs[1]  = '{1, 1, 2, 3'b000, 20, 0, 3'b000, 0, 0, 0};  // bouncing button
      vecs[2]  = '{1, 0, 0, 3'b000, 10, 0, 3'b000, 0, 0, 0};
      vecs[3]  = '{1, 1, 0, 3'b000, 10, 1, 3'b000, 1, 0, 0};  // start
      vecs[4]  = '{1, 0, 0, 3'b000, 10, 1, 3'b000, 0, 0, 0};
      vecs[5]  = '{1, 1, 0, 3'b000, 7,  1, 3'b000, 0, 0, 0};  // press one short of long
      vecs[6]  = '{1, 0, 0, 3'b000, 10, 1, 3'b000, 0, 0, 0};
      vecs[7]  = '{1, 1, 0, 3'b000, 7,  1, 3'b000, 0, 0, 0};
      vecs[8]  = '{1, 0, 0, 3'b000, 10, 1, 3'b000, 0, 0, 0};
      vecs[9]  = '{1, 1, 0, 3'b000, 20, 0, 3'b000, 0, 1, 0};  // long press stops
      vecs[10] = '{1, 0, 0, 3'b000, 10, 0, 3'b000, 0, 0, 0};
      vecs[11] = '{1, 0, 0, 3'b101, 10, 0, 3'b101, 0, 0, 1};
      vecs[12] = '{1, 1, 0, 3'b101, 10, 1, 3'b101, 1, 0, 0};
      vecs[13] = '{1, 0, 0, 3'b010, 12, 1, 3'b101, 0, 0, 0};  // frozen while running
      vecs[14] = '{1, 1, 0, 3'b010, 20, 0, 3'b101, 0, 1, 0};
      vecs[15] = '{1, 0, 0, 3'b010, 10, 0, 3'b010, 0, 0, 1};  // pending value applied
      vecs[16] = '{1, 1, 0, 3'b010, 10, 1, 3'b010, 1, 0, 0};
      vecs[17] = '{1, 0, 0, 3'b010, 10, 1, 3'b010, 0, 0, 0};
      vecs[18] = '{1, 1, 0, 3'b010, 8,  1, 3'b010, 0, 0, 0};
      vecs[19] = '{0, 1, 0, 3'b010, 1,  0, 3'b000, 0, 0, 0};  // reset mid-press
      vecs[20] = '{1, 1, 0, 3'b010, 10, 1, 3'b010, 1, 0, 1};
      vecs[21] = '{1, 0, 0, 3'b010, 10, 1, 3'b010, 0, 0, 0};

      for (int v = 0; v < 22; v++) begin
         rst_n          = vecs[v].rst;
         bus.button_raw = vecs[v].btn;
         bus.switch_raw = vecs[v].sw;
         s0 = n_start; s1 = n_stop; s2 = n_chg;
         for (int i = 0; i < vecs[v].n; i++) begin
            tick();
            if (vecs[v].tog != 0 && ((i + 1) % vecs[v].tog) == 0) bus.button_raw = ~bus.button_raw;
         end
         check($sformatf("seg%0d_run", v), 32'(bus.run), 32'(vecs[v].e_run));
         check($sformatf("seg%0d_pattern", v), 32'(bus.pattern), 32'(vecs[v].e_pat));
         check($sformatf("seg%0d_starts", v), n_start - s0, vecs[v].e_start);
         check($sformatf("seg%0d_stops", v), n_stop - s1, vecs[v].e_stop);
         check($sformatf("seg%0d_chgs", v), n_chg - s2, vecs[v].e_chg);
      end

      // Random button/switch activity with occasional resets.
      rst_n = 1'b1;
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 19) == 0) begin
            rst_n = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
            rst_n = 1'b1;
         end
         bus.button_raw = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) bus.switch_raw = 3'($urandom_range(0, 7));
         repeat ($urandom_range(1, 20)) tick();
      end

      // Exact start latency from a clean reset.
      rst_n = 1'b0; bus.button_raw = 1'b0; bus.switch_raw = 3'b000;
      repeat (2) tick();
      rst_n = 1'b1;
      bus.button_raw = 1'b1;
      lat = 0; found = 0; run_at = 1'b0;
      for (int i = 1; i <= 20 && found == 0; i++) begin
         tick();
         if (bus.start_pulse === 1'b1) begin lat = i; found = 1; run_at = bus.run; end
      end
      check("start_latency", lat, 2 + Deb + 1);
      check("run_on_start", 32'(run_at), 1);

      // Exact long-press latency, then no restart while still held.
      bus.button_raw = 1'b0;
      repeat (10) tick();
      bus.button_raw = 1'b1;
      lat = 0; found = 0; run_at = 1'b1;
      for (int i = 1; i <= 40 && found == 0; i++) begin
         tick();
         if (bus.stop_pulse === 1'b1) begin lat = i; found = 1; run_at = bus.run; end
      end
      check("stop_latency", lat, 2 + Deb + Long);
      check("run_on_stop", 32'(run_at), 0);
      s0 = n_start;
      repeat (12) tick();
      check("no_restart_while_held", n_start - s0, 0);
      bus.button_raw = 1'b0;
      repeat (10) tick();
      check("stopped_after_release", 32'(bus.run), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
